// File: rtl/instr_issue_queue_if.sv
// -----------------------------------------------------------------------------
// instr_issue_queue_if
// Groups the two streaming handshakes of the issue queue:
//   write side : i_wr_instr / i_wr_valid  ->  o_wr_ready
//   issue side : o_instr / o_valid        ->  i_ready (from CORE)
// Signal names are as seen from the queue. The queue uses the slave modport;
// the producer/consumer environment uses the master modport.
// -----------------------------------------------------------------------------
interface instr_issue_queue_if;
    logic [31:0] i_wr_instr;
    logic        i_wr_valid;
    logic        o_wr_ready;
    logic [31:0] o_instr;
    logic        o_valid;
    logic        i_ready;

    modport slave (
        input  i_wr_instr, i_wr_valid, i_ready,
        output o_wr_ready, o_instr, o_valid
    );

    modport master (
        output i_wr_instr, i_wr_valid, i_ready,
        input  o_wr_ready, o_instr, o_valid
    );
endinterface

// File: rtl/instr_issue_queue.sv
// -----------------------------------------------------------------------------
// instr_issue_queue
// Instruction FIFO plus run/halt issue sequencer feeding CORE.
// Instruction format: {op[1:0], rd[4:0], rs1[4:0], rs2[4:0], 15'd0}.
// An instruction whose op equals HALT_OP is consumed here, never issued, and
// parks the sequencer in HALTED until the next i_start.
//
// Ports:
//   i_CLK, i_RSTn  clock, asynchronous active-low reset
//   bus            write handshake (i_wr_instr/i_wr_valid/o_wr_ready) and
//                  issue handshake (o_instr/o_valid/i_ready)
//   i_start        pulse: IDLE->RUN or HALTED->RUN
//   i_flush        pulse: empty FIFO, drop output, clear counter, go IDLE
//   o_level        FIFO occupancy (output register not included)
//   o_issued       completed handshakes, wraps modulo 2^CNT_WIDTH
//   o_busy         sequencer in RUN
//   o_halted       sequencer in HALTED
// -----------------------------------------------------------------------------
module instr_issue_queue #(
    parameter int         DEPTH     = 8,
    parameter int         CNT_WIDTH = 8,
    parameter logic [1:0] HALT_OP   = 2'b11
) (
    input  logic                       i_CLK,
    input  logic                       i_RSTn,
    instr_issue_queue_if.slave         bus,
    input  logic                       i_start,
    input  logic                       i_flush,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic [CNT_WIDTH-1:0]       o_issued,
    output logic                       o_busy,
    output logic                       o_halted
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [31:0]            r_mem [DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [LVL_W-1:0]       r_level;
    logic [31:0]            r_instr;
    logic                   r_valid;
    logic [CNT_WIDTH-1:0]   r_issued;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_xfer;
    logic                   w_slot_free;
    logic [31:0]            w_head;
    logic                   w_head_halt;
    logic                   w_pop;
    logic                   w_pop_instr;
    logic                   w_pop_halt;

    // Full/empty come from the occupancy counter, so the pointers may wrap freely.
    assign w_full      = (r_level == LVL_W'(DEPTH));
    assign w_empty     = (r_level == '0);

    // No pass-through: readiness depends on occupancy alone, not on a same-edge pop.
    assign bus.o_wr_ready = !w_full;
    assign w_push      = bus.i_wr_valid && !w_full && !i_flush;

    assign w_xfer      = r_valid && bus.i_ready;
    assign w_slot_free = !r_valid || w_xfer;

    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_halt = (w_head[31:30] == HALT_OP);

    // Pops happen only in RUN, only into a free output slot, never on a flush.
    assign w_pop       = (r_state == ST_RUN) && !w_empty && w_slot_free && !i_flush;
    assign w_pop_instr = w_pop && !w_head_halt;
    assign w_pop_halt  = w_pop &&  w_head_halt;

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state is always assigned with non-blocking (<=) so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // ---------------- FSM: next-state logic ----------------
    // NOTE: the default assignment at the top keeps this block free of latches.
    always_comb begin
        w_state_nxt = r_state;
        if (i_flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE:   if (i_start)    w_state_nxt = ST_RUN;
                ST_RUN:    if (w_pop_halt) w_state_nxt = ST_HALTED;
                ST_HALTED: if (i_start)    w_state_nxt = ST_RUN;
                default:                   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // ---------------- FSM: output logic ----------------
    always_comb begin
        o_busy   = (r_state == ST_RUN);
        o_halted = (r_state == ST_HALTED);
    end

    // ---------------- FIFO storage ----------------
    // NOTE: the storage array has no reset; validity is tracked entirely by
    // the pointers and r_level, which keeps the array a plain RAM.
    always_ff @(posedge i_CLK) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.i_wr_instr;
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            // A discarded HALT still leaves the FIFO, so it counts as a pop.
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // ---------------- Output register and issue counter ----------------
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            r_instr  <= '0;
            r_valid  <= 1'b0;
            r_issued <= '0;
        end else if (i_flush) begin
            r_valid  <= 1'b0;
            r_issued <= '0;
        end else begin
            if (w_xfer) r_issued <= r_issued + CNT_WIDTH'(1);
            // r_instr only changes when the slot is free, so it stays stable
            // while a transfer is pending.
            if (w_pop_instr) begin
                r_instr <= w_head;
                r_valid <= 1'b1;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.o_instr = r_instr;
    assign bus.o_valid = r_valid;
    assign o_level     = r_level;
    assign o_issued    = r_issued;

endmodule

// File: tb/tb_instr_issue_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_issue_queue
// Directed scenarios plus randomized traffic. A queue-based reference model
// tracks what the block must present; a negedge process compares every output
// against it each cycle, and directed scenarios pin literal values.
// -----------------------------------------------------------------------------
module tb_instr_issue_queue;

    localparam int DEPTH = 8;
    localparam int IDLE = 0, RUN = 1, HALTED = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       flush = 1'b0;
    logic [3:0] level;
    logic [7:0] issued;
    logic       busy;
    logic       halted;

    instr_issue_queue_if bus ();

    instr_issue_queue #(.DEPTH(DEPTH), .CNT_WIDTH(8), .HALT_OP(2'b11)) dut (
        .i_CLK    (clk),
        .i_RSTn   (rst_n),
        .bus      (bus),
        .i_start  (start),
        .i_flush  (flush),
        .o_level  (level),
        .o_issued (issued),
        .o_busy   (busy),
        .o_halted (halted)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- Reference model ----------------
    logic [31:0] mq[$];
    logic [31:0] log_q[$];
    int          m_mode;
    bit          m_valid;
    logic [31:0] m_instr;
    int          m_issued;
    int          nxt_mode;
    bit          xfer, free, accept, nv;
    logic [31:0] h;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete(); log_q.delete();
            m_mode = IDLE; m_valid = 0; m_instr = 0; m_issued = 0;
        end else if (flush) begin
            mq.delete();
            m_mode = IDLE; m_valid = 0; m_issued = 0;
        end else begin
            xfer   = m_valid && bus.i_ready;
            free   = !m_valid || xfer;
            accept = bus.i_wr_valid && (mq.size() < DEPTH);
            nxt_mode = m_mode;
            nv = xfer ? 1'b0 : m_valid;
            if (xfer) begin
                log_q.push_back(m_instr);
                m_issued++;
            end
            if (m_mode == RUN && mq.size() != 0 && free) begin
                h = mq.pop_front();
                if (h[31:30] == 2'b11) nxt_mode = HALTED;
                else begin
                    m_instr = h;
                    nv = 1'b1;
                end
            end
            if (start && m_mode != RUN) nxt_mode = RUN;
            if (accept) mq.push_back(bus.i_wr_instr);
            m_mode  = nxt_mode;
            m_valid = nv;
        end
    end

    // ---------------- Per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check("valid",    {31'd0, bus.o_valid},    {31'd0, m_valid});
            if (m_valid) check("instr", bus.o_instr, m_instr);
            check("level",    {28'd0, level},          mq.size());
            check("wr_ready", {31'd0, bus.o_wr_ready}, {31'd0, mq.size() < DEPTH});
            check("issued",   {24'd0, issued},         m_issued % 256);
            check("busy",     {31'd0, busy},           {31'd0, m_mode == RUN});
            check("halted",   {31'd0, halted},         {31'd0, m_mode == HALTED});
        end
    end

    // ---------------- Stimulus helpers ----------------
    // Inputs change just after a negedge and take effect at the next posedge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [31:0] w);
        bus.i_wr_instr = w;
        bus.i_wr_valid = 1'b1;
        tick();
        bus.i_wr_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        bus.i_wr_valid = 1'b0;
        bus.i_wr_instr = '0;
        bus.i_ready    = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic check_log(input string name, input logic [31:0] exp[$]);
        check({name, "_count"}, log_q.size(), exp.size());
        for (int k = 0; k < exp.size() && k < log_q.size(); k++)
            check(name, log_q[k], exp[k]);
    endtask

    localparam logic [31:0] W_ADD  = 32'h06110000;
    localparam logic [31:0] W_SUB  = 32'h48308000;
    localparam logic [31:0] W_AND  = 32'h8A110000;
    localparam logic [31:0] W_HALT = 32'hC0000000;

    initial begin
        logic [31:0] exp_q[$];
        logic [31:0] w;

        bus.i_wr_valid = 1'b0;
        bus.i_wr_instr = '0;
        bus.i_ready    = 1'b0;
        do_reset();
        chk_en = 1'b1;

        // Reset state
        check("rst_valid",    {31'd0, bus.o_valid},    0);
        check("rst_instr",    bus.o_instr,             0);
        check("rst_level",    {28'd0, level},          0);
        check("rst_issued",   {24'd0, issued},         0);
        check("rst_busy",     {31'd0, busy},           0);
        check("rst_halted",   {31'd0, halted},         0);
        check("rst_wr_ready", {31'd0, bus.o_wr_ready}, 1);

        // 1: three words back to back
        push(W_ADD); push(W_SUB); push(W_AND);
        bus.i_ready = 1'b1;
        pulse_start();
        tick(6);
        exp_q = '{W_ADD, W_SUB, W_AND};
        check_log("t1_log", exp_q);
        check("t1_issued", {24'd0, issued}, 3);
        check("t1_level",  {28'd0, level},  0);
        check("t1_busy",   {31'd0, busy},   1);

        // 2: stall four cycles after first valid
        do_reset();
        push(W_ADD); push(W_SUB); push(W_AND);
        pulse_start();
        tick();
        check("t2_first_valid", {31'd0, bus.o_valid}, 1);
        for (int k = 0; k < 4; k++) begin
            check("t2_hold", bus.o_instr, W_ADD);
            tick();
        end
        bus.i_ready = 1'b1;
        tick(6);
        check_log("t2_log", exp_q);
        check("t2_issued", {24'd0, issued}, 3);

        // 3: HALT in the stream
        do_reset();
        bus.i_ready = 1'b1;
        push(W_ADD); push(W_HALT); push(W_AND);
        pulse_start();
        tick(5);
        exp_q = '{W_ADD};
        check_log("t3_log_a", exp_q);
        check("t3_halted", {31'd0, halted}, 1);
        check("t3_level",  {28'd0, level},  1);
        check("t3_valid",  {31'd0, bus.o_valid}, 0);
        pulse_start();
        tick(4);
        exp_q = '{W_ADD, W_AND};
        check_log("t3_log_b", exp_q);
        check("t3_issued", {24'd0, issued}, 2);

        // 4: overfill while IDLE
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 9; i++) begin
            w = {2'b01, 5'(i), 5'(i + 1), 5'(i + 2), 15'd0};
            if (i < 8) exp_q.push_back(w);
            push(w);
            if (i == 7) check("t4_full_ready", {31'd0, bus.o_wr_ready}, 0);
        end
        check("t4_level", {28'd0, level}, 8);
        bus.i_ready = 1'b1;
        pulse_start();
        tick(12);
        check_log("t4_log", exp_q);
        check("t4_issued", {24'd0, issued}, 8);

        // 5: flush with pending output and same-edge write
        do_reset();
        push(W_ADD); push(W_SUB); push(W_AND);
        bus.i_ready = 1'b1;
        pulse_start();
        tick();
        tick();
        bus.i_ready = 1'b0;
        tick();
        check("t5_pre_valid",  {31'd0, bus.o_valid}, 1);
        check("t5_pre_issued", {24'd0, issued},      1);
        flush = 1'b1;
        bus.i_wr_valid = 1'b1;
        bus.i_wr_instr = W_SUB;
        tick();
        flush = 1'b0;
        bus.i_wr_valid = 1'b0;
        check("t5_valid",  {31'd0, bus.o_valid}, 0);
        check("t5_level",  {28'd0, level},       0);
        check("t5_issued", {24'd0, issued},      0);
        check("t5_busy",   {31'd0, busy},        0);
        check("t5_halted", {31'd0, halted},      0);

        // 6: asynchronous reset mid-stream
        do_reset();
        push(W_ADD); push(W_SUB); push(W_AND); push(W_ADD);
        bus.i_ready = 1'b0;
        pulse_start();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_valid", {31'd0, bus.o_valid}, 0);
        check("t6_level", {28'd0, level},       0);
        check("t6_busy",  {31'd0, busy},        0);
        tick();
        rst_n = 1'b1;
        tick();

        // 7: randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            bus.i_wr_valid = ($urandom_range(0, 99) < 55);
            w = $urandom();
            if ($urandom_range(0, 5) == 0) w[31:30] = 2'b11;
            else if (w[31:30] == 2'b11) w[31:30] = 2'b00;
            bus.i_wr_instr = w;
            bus.i_ready = ($urandom_range(0, 99) < 65);
            start = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 149) == 0);
            tick();
        end
        bus.i_wr_valid = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_issue_queue.md
Name: instr_issue_queue

Overview:
Instruction buffer and issue sequencer directly upstream of CORE. A host or loader pushes 32-bit instructions into an internal FIFO. A run/halt state machine then issues them one at a time to CORE over a valid/ready handshake. Instruction format is {op[1:0], rd[4:0], rs1[4:0], rs2[4:0], 15'd0}. Opcode 2'b11 is the HALT marker: it is consumed here and never forwarded to CORE.

Parameters:
DEPTH, 8, FIFO entries; must be a power of 2 and at least 2.
CNT_WIDTH, 8, width of the issued-instruction counter.
HALT_OP, 2'b11, opcode value treated as HALT.

Ports:
i_CLK  in  1  clock; all state updates on the rising edge.
i_RSTn  in  1  asynchronous active-low reset.
i_wr_instr  in  32  instruction to enqueue.
i_wr_valid  in  1  enqueue request.
o_wr_ready  out  1  FIFO not full; combinational from the occupancy register.
i_start  in  1  single-cycle pulse; IDLE->RUN or HALTED->RUN.
i_flush  in  1  single-cycle pulse; discards everything and returns to IDLE.
o_instr  out  32  registered instruction to CORE (drives CORE i_instr).
o_valid  out  1  registered; o_instr holds an unissued instruction (drives CORE i_valid).
i_ready  in  1  CORE o_ready.
o_level  out  $clog2(DEPTH)+1  FIFO occupancy; excludes the output register.
o_issued  out  CNT_WIDTH  count of completed handshakes; wraps modulo 2^CNT_WIDTH.
o_busy  out  1  high when state==RUN.
o_halted  out  1  high when state==HALTED.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - state=IDLE; FIFO empty; o_level=0.
  - o_valid=0, o_instr=0, o_issued=0, o_busy=0, o_halted=0.
- Enqueue: on an edge with i_wr_valid && o_wr_ready, the instruction is written at the tail and o_level increments.
  - A write while full is dropped; the FIFO is not modified.
  - Writes are accepted in every state.
  - There is no pass-through: a write into a full FIFO is refused even if a pop occurs on the same edge.
- Handshake: a transfer completes on an edge with o_valid && i_ready.
  - On that edge o_issued increments.
  - o_valid and o_instr must hold stable until the transfer completes.
- Output slot free: true when o_valid==0, or when a transfer completes on this edge.
- State IDLE:
  - No pops.
  - i_start -> RUN.
- State RUN, head is a normal instruction (FIFO non-empty, head op != HALT_OP, slot free):
  - Pop the head into o_instr; o_valid=1 next cycle.
  - Back-to-back issue sustains 1 instruction per cycle while i_ready stays high.
- State RUN, head op == HALT_OP (slot free):
  - Pop the HALT and discard it; state->HALTED.
  - o_valid goes low next cycle if the slot was drained this edge.
  - HALT is never placed in o_instr.
- State RUN, FIFO empty: remain in RUN with o_valid low once the slot drains.
- State HALTED:
  - No pops. A pending o_valid cannot exist in this state (the slot was free when HALT popped).
  - i_start -> RUN; the remaining queue contents resume issuing.
- i_start while already in RUN is ignored.
- Latency: a write into an empty FIFO in RUN gives o_valid=1 two edges after the write edge (write edge, then pop edge).
- Simultaneous push and pop when not full: both occur; o_level is unchanged.
- i_flush, highest priority over all other actions on the same edge:
  - FIFO emptied; pointers reset; any same-edge write is dropped.
  - o_valid=0; o_issued=0; state=IDLE.
  - A same-edge handshake does not increment the counter.
- Pointer arithmetic: read and write pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are derived from the occupancy counter, not from pointer comparison.

Test Plan:
- Reset, write ADD 32'h06110000, SUB 32'h48308000, AND 32'h8A110000, pulse i_start with i_ready=1 -> o_instr carries the three words on consecutive cycles; o_issued=3; o_level=0; o_busy=1.
- Same three words, i_ready low for 4 cycles after the first o_valid -> o_instr holds 32'h06110000 stable; no loss or duplication; o_issued=3 at the end.
- Write 32'h06110000, 32'hC0000000, 32'h8A110000, start -> only 32'h06110000 issued; o_halted=1; o_level=1. Pulse i_start -> 32'h8A110000 issued; o_issued=2.
- Write 9 words with DEPTH=8 while IDLE -> o_wr_ready=0 after the 8th; 9th dropped; o_level=8. Start with i_ready=1 -> exactly 8 issued, in order.
- In RUN with o_valid=1 and i_ready=0, pulse i_flush together with i_wr_valid -> next cycle o_valid=0, o_level=0, o_issued=0, state IDLE.
- Deassert i_RSTn mid-stream -> o_valid=0 and o_level=0 immediately, without waiting for a clock edge.
